// File: rtl/ctrl_sig_pkg.sv
// Shared control-signal encodings for the MC-RV32EC integer pipeline:
// ALU category/select, PC mode, LSU width, opcodes and the decode bundle.
package ctrl_sig_pkg;

   typedef enum logic [1:0] {ALUBT = 2'b00, ALUAS = 2'b01, ALUSH = 2'b10, ALUFL = 2'b11} alu_cat_e;
   typedef enum logic [1:0] {BTXOR = 2'b00, BTOR = 2'b01, BTAND = 2'b10} bt_sel_e;
   typedef enum logic [1:0] {AFEQU = 2'b00, AFADD = 2'b01, AFSUBU = 2'b10, AFSUBS = 2'b11} af_sel_e;
   typedef enum logic [1:0] {SHSLL = 2'b00, SHSRL = 2'b01, SHSRA = 2'b10} sh_sel_e;
   typedef enum logic [1:0] {PCINC = 2'b00, PCBRCH = 2'b01, PCJREG = 2'b10, PCJIMM = 2'b11} pc_mode_e;
   typedef enum logic [1:0] {LSN = 2'b00, LSW = 2'b01, LSH = 2'b10, LSB = 2'b11} lsu_width_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [1:0] OPA_RS1  = 2'b00;
   localparam logic [1:0] OPA_PC   = 2'b01;
   localparam logic [1:0] OPA_ZERO = 2'b10;

   // Everything the stage registers except the PC; all-zero is the NOP bundle.
   typedef struct packed {
      logic [3:0]  alu_op;       // {alu_cat_e, select}
      logic        flag_inv;
      pc_mode_e    pc_mode;
      lsu_width_e  lsu_width;
      logic        lsu_store;
      logic        lsu_unsigned;
      logic [1:0]  opa_sel;
      logic        opb_sel;
      logic [31:0] imm;
      logic [3:0]  rd_addr;
      logic [3:0]  rs1_addr;
      logic [3:0]  rs2_addr;
      logic        rd_write;
      logic        illegal;
   } ctrl_bundle_t;

   function automatic logic [31:0] imm_i(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[31:25], instr[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] instr);
      return {instr[31:12], 12'h000};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] instr);
      return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/rv32e_decoder.sv
// Combinational RV32E decoder: one 32-bit instruction in, control bundle out.
// Illegal encodings collapse to the NOP bundle with only the illegal flag set.
module rv32e_decoder
   import ctrl_sig_pkg::*;
(
   input  logic [31:0]  instr,
   output ctrl_bundle_t ctrl
);

   logic [6:0]   opcode;
   logic [2:0]   funct3;
   logic [6:0]   funct7;
   ctrl_bundle_t dec;
   alu_cat_e     cat;
   logic [1:0]   sel;
   logic         bad;
   logic         use_rd;
   logic         use_rs1;
   logic         use_rs2;
   logic         reg_bad;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Field decode per opcode, then register-index gating and the illegal collapse
   always_comb begin
      dec     = '0;
      ctrl    = '0;
      cat     = ALUBT;
      sel     = 2'b00;
      bad     = 1'b0;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      reg_bad = 1'b0;
      case (opcode)
         OPC_OP, OPC_OPIMM: begin
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            if (opcode == OPC_OP) begin
               use_rs2 = 1'b1;
               bad = ~((funct7 == 7'h00) |
                       ((funct7 == 7'h20) & ((funct3 == 3'b000) | (funct3 == 3'b101))));
            end else begin
               dec.opb_sel = 1'b1;
               dec.imm     = imm_i(instr);
               if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                  bad = ~((funct7 == 7'h00) | (funct7 == 7'h20));
               end else begin
                  bad = 1'b0;
               end
            end
            case (funct3)
               3'b000: begin
                  cat = ALUAS;
                  sel = ((opcode == OPC_OP) && funct7[5]) ? AFSUBU : AFADD;
               end
               3'b001: begin cat = ALUSH; sel = SHSLL; end
               3'b010: begin cat = ALUFL; sel = AFSUBS; dec.flag_inv = 1'b1; end
               3'b011: begin cat = ALUFL; sel = AFSUBU; dec.flag_inv = 1'b1; end
               3'b100: begin cat = ALUBT; sel = BTXOR; end
               3'b101: begin cat = ALUSH; sel = funct7[5] ? SHSRA : SHSRL; end
               3'b110: begin cat = ALUBT; sel = BTOR; end
               3'b111: begin cat = ALUBT; sel = BTAND; end
               default: begin cat = ALUBT; sel = 2'b00; end
            endcase
         end
         OPC_BRANCH: begin
            use_rs1     = 1'b1;
            use_rs2     = 1'b1;
            cat         = ALUFL;
            dec.pc_mode = PCBRCH;
            dec.imm     = imm_b(instr);
            case (funct3)
               3'b000:  begin sel = AFEQU;  dec.flag_inv = 1'b0; end
               3'b001:  begin sel = AFEQU;  dec.flag_inv = 1'b1; end
               3'b100:  begin sel = AFSUBS; dec.flag_inv = 1'b1; end
               3'b101:  begin sel = AFSUBS; dec.flag_inv = 1'b0; end
               3'b110:  begin sel = AFSUBU; dec.flag_inv = 1'b1; end
               3'b111:  begin sel = AFSUBU; dec.flag_inv = 1'b0; end
               default: begin sel = AFEQU;  bad = 1'b1; end
            endcase
         end
         OPC_LUI, OPC_AUIPC: begin
            use_rd      = 1'b1;
            cat         = ALUAS;
            sel         = AFADD;
            dec.opa_sel = (opcode == OPC_LUI) ? OPA_ZERO : OPA_PC;
            dec.opb_sel = 1'b1;
            dec.imm     = imm_u(instr);
         end
         OPC_JAL: begin
            // Target computed as PC + J-immediate; link value comes from PC logic
            use_rd      = 1'b1;
            cat         = ALUAS;
            sel         = AFADD;
            dec.pc_mode = PCJIMM;
            dec.opa_sel = OPA_PC;
            dec.opb_sel = 1'b1;
            dec.imm     = imm_j(instr);
         end
         OPC_JALR: begin
            use_rd      = 1'b1;
            use_rs1     = 1'b1;
            cat         = ALUAS;
            sel         = AFADD;
            dec.pc_mode = PCJREG;
            dec.opb_sel = 1'b1;
            dec.imm     = imm_i(instr);
            bad         = (funct3 != 3'b000);
         end
         OPC_LOAD: begin
            use_rd      = 1'b1;
            use_rs1     = 1'b1;
            cat         = ALUAS;
            sel         = AFADD;
            dec.opb_sel = 1'b1;
            dec.imm     = imm_i(instr);
            case (funct3)
               3'b000:  dec.lsu_width = LSB;
               3'b001:  dec.lsu_width = LSH;
               3'b010:  dec.lsu_width = LSW;
               3'b100:  begin dec.lsu_width = LSB; dec.lsu_unsigned = 1'b1; end
               3'b101:  begin dec.lsu_width = LSH; dec.lsu_unsigned = 1'b1; end
               default: bad = 1'b1;
            endcase
         end
         OPC_STORE: begin
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
            cat           = ALUAS;
            sel           = AFADD;
            dec.opb_sel   = 1'b1;
            dec.lsu_store = 1'b1;
            dec.imm       = imm_s(instr);
            case (funct3)
               3'b000:  dec.lsu_width = LSB;
               3'b001:  dec.lsu_width = LSH;
               3'b010:  dec.lsu_width = LSW;
               default: bad = 1'b1;
            endcase
         end
         default: bad = 1'b1;
      endcase

      dec.alu_op   = {cat, sel};
      // Unused register fields read as zero so downstream hazard logic ignores them
      dec.rd_addr  = use_rd  ? instr[10:7]  : 4'h0;
      dec.rs1_addr = use_rs1 ? instr[18:15] : 4'h0;
      dec.rs2_addr = use_rs2 ? instr[23:20] : 4'h0;
      dec.rd_write = use_rd & (instr[11:7] != 5'd0);
      // RV32E only has x0..x15
      reg_bad = (use_rd & instr[11]) | (use_rs1 & instr[19]) | (use_rs2 & instr[24]);

      if (bad | reg_bad) begin
         ctrl         = '0;
         ctrl.illegal = 1'b1;
      end else begin
         ctrl = dec;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: rv32e_decoder output captured into a 2-entry
// skid buffer so that the upstream ready is driven from a flop.
module decode_stage
   import ctrl_sig_pkg::*;
#(
   parameter logic [31:0] ResetPc = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        InValid,
   output logic        InReady,
   input  logic [31:0] InInstr,
   input  logic [31:0] InPc,
   input  logic        Flush,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [31:0] OutPc,
   output logic [3:0]  CtrlALUOp,
   output logic        CtrlFlagInv,
   output logic [1:0]  CtrlPCMode,
   output logic [1:0]  CtrlLSUWidth,
   output logic        CtrlLSUStore,
   output logic        CtrlLSUUnsigned,
   output logic [1:0]  CtrlOpASel,
   output logic        CtrlOpBSel,
   output logic [31:0] Imm,
   output logic [3:0]  RdAddr,
   output logic [3:0]  Rs1Addr,
   output logic [3:0]  Rs2Addr,
   output logic        RdWrite,
   output logic        Illegal
);

   ctrl_bundle_t dec;
   ctrl_bundle_t main_ctrl;
   ctrl_bundle_t skid_ctrl;
   logic [31:0]  main_pc;
   logic [31:0]  skid_pc;
   logic         main_valid;
   logic         skid_valid;
   logic         accept;

   rv32e_decoder u_decoder (
      .instr (InInstr),
      .ctrl  (dec)
   );

   assign InReady = ~skid_valid;
   assign accept  = InValid & ~skid_valid;

   // Skid buffer: main drives outputs; skid catches the beat accepted while main stalls
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_ctrl  <= '0;
         skid_ctrl  <= '0;
         main_pc    <= ResetPc;
         skid_pc    <= 32'h0000_0000;
      end else if (Flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (~main_valid | OutReady) begin
         if (skid_valid) begin
            main_ctrl  <= skid_ctrl;
            main_pc    <= skid_pc;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_ctrl  <= dec;
            main_pc    <= InPc;
            main_valid <= 1'b1;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_ctrl  <= dec;
         skid_pc    <= InPc;
         skid_valid <= 1'b1;
      end
   end

   assign OutValid        = main_valid;
   assign OutPc           = main_pc;
   assign CtrlALUOp       = main_ctrl.alu_op;
   assign CtrlFlagInv     = main_ctrl.flag_inv;
   assign CtrlPCMode      = main_ctrl.pc_mode;
   assign CtrlLSUWidth    = main_ctrl.lsu_width;
   assign CtrlLSUStore    = main_ctrl.lsu_store;
   assign CtrlLSUUnsigned = main_ctrl.lsu_unsigned;
   assign CtrlOpASel      = main_ctrl.opa_sel;
   assign CtrlOpBSel      = main_ctrl.opb_sel;
   assign Imm             = main_ctrl.imm;
   assign RdAddr          = main_ctrl.rd_addr;
   assign Rs1Addr         = main_ctrl.rs1_addr;
   assign Rs2Addr         = main_ctrl.rs2_addr;
   assign RdWrite         = main_ctrl.rd_write;
   assign Illegal         = main_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed spec cases plus a random
// stream checked against an instruction-level reference model and a FIFO
// model of the two-entry buffer.
`timescale 1ns/1ps
module tb_decode_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_1000;

   // Expected ALU encodings as {category, select}
   localparam logic [3:0] A_ADD  = 4'b0101;
   localparam logic [3:0] A_SUB  = 4'b0110;
   localparam logic [3:0] A_EQ   = 4'b1100;
   localparam logic [3:0] A_LTU  = 4'b1110;
   localparam logic [3:0] A_LTS  = 4'b1111;
   localparam logic [3:0] A_XOR  = 4'b0000;
   localparam logic [3:0] A_OR   = 4'b0001;
   localparam logic [3:0] A_AND  = 4'b0010;
   localparam logic [3:0] A_SLL  = 4'b1000;
   localparam logic [3:0] A_SRL  = 4'b1001;
   localparam logic [3:0] A_SRA  = 4'b1010;

   typedef struct packed {
      logic [3:0]  alu;
      logic        inv;
      logic [1:0]  pcm;
      logic [1:0]  lw;
      logic        st;
      logic        un;
      logic [1:0]  opa;
      logic        opb;
      logic [31:0] imm;
      logic [3:0]  rd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic        rdw;
      logic        ill;
   } exp_t;

   typedef struct packed {
      exp_t        c;
      logic [31:0] pc;
   } entry_t;

   logic        clk = 1'b0;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [31:0] InInstr;
   logic [31:0] InPc;
   logic        Flush;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] OutPc;
   logic [3:0]  CtrlALUOp;
   logic        CtrlFlagInv;
   logic [1:0]  CtrlPCMode;
   logic [1:0]  CtrlLSUWidth;
   logic        CtrlLSUStore;
   logic        CtrlLSUUnsigned;
   logic [1:0]  CtrlOpASel;
   logic        CtrlOpBSel;
   logic [31:0] Imm;
   logic [3:0]  RdAddr;
   logic [3:0]  Rs1Addr;
   logic [3:0]  Rs2Addr;
   logic        RdWrite;
   logic        Illegal;

   int n_checks = 0;
   int n_errors = 0;

   decode_stage #(.ResetPc(RESET_PC)) dut (
      .Clk(clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .InInstr(InInstr), .InPc(InPc), .Flush(Flush), .OutValid(OutValid),
      .OutReady(OutReady), .OutPc(OutPc), .CtrlALUOp(CtrlALUOp),
      .CtrlFlagInv(CtrlFlagInv), .CtrlPCMode(CtrlPCMode),
      .CtrlLSUWidth(CtrlLSUWidth), .CtrlLSUStore(CtrlLSUStore),
      .CtrlLSUUnsigned(CtrlLSUUnsigned), .CtrlOpASel(CtrlOpASel),
      .CtrlOpBSel(CtrlOpBSel), .Imm(Imm), .RdAddr(RdAddr), .Rs1Addr(Rs1Addr),
      .Rs2Addr(Rs2Addr), .RdWrite(RdWrite), .Illegal(Illegal)
   );

   always #5 clk = ~clk;

   function automatic exp_t observe();
      exp_t o;
      o = {CtrlALUOp, CtrlFlagInv, CtrlPCMode, CtrlLSUWidth, CtrlLSUStore,
           CtrlLSUUnsigned, CtrlOpASel, CtrlOpBSel, Imm, RdAddr, Rs1Addr,
           Rs2Addr, RdWrite, Illegal};
      return o;
   endfunction

   function automatic logic [3:0] arith(input logic [2:0] f3, input logic alt);
      logic [3:0] tbl [8];
      tbl = '{A_ADD, A_SLL, A_LTS, A_LTU, A_XOR, A_SRL, A_OR, A_AND};
      if (alt && f3 == 3'd0) return A_SUB;
      if (alt && f3 == 3'd5) return A_SRA;
      return tbl[f3];
   endfunction

   // Reference model: expected bundle straight from the instruction-set rules
   function automatic exp_t model(input logic [31:0] i);
      exp_t e;
      logic legal, ur, u1, u2;
      logic [2:0] f3;
      logic [6:0] f7;
      int t;
      logic [31:0] ii, is, ib, iu, ij;
      f3 = i[14:12];
      f7 = i[31:25];
      t = $signed(i[31:20]);                                          ii = t;
      t = $signed({i[31:25], i[11:7]});                               is = t;
      t = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});            ib = t;
      iu = {i[31:12], 12'h000};
      t = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});          ij = t;
      e = '0; legal = 1'b1; ur = 1'b0; u1 = 1'b0; u2 = 1'b0;
      case (i[6:0])
         7'h33: begin
            ur = 1'b1; u1 = 1'b1; u2 = 1'b1;
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            e.alu = arith(f3, f7[5]);
            e.inv = (f3 == 3'd2 || f3 == 3'd3);
         end
         7'h13: begin
            ur = 1'b1; u1 = 1'b1;
            legal = (f3 == 3'd1 || f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            e.alu = arith(f3, (f3 == 3'd5) && f7[5]);
            e.inv = (f3 == 3'd2 || f3 == 3'd3);
            e.opb = 1'b1; e.imm = ii;
         end
         7'h63: begin
            u1 = 1'b1; u2 = 1'b1; e.pcm = 2'b01; e.imm = ib;
            case (f3)
               3'd0: begin e.alu = A_EQ;  e.inv = 1'b0; end
               3'd1: begin e.alu = A_EQ;  e.inv = 1'b1; end
               3'd4: begin e.alu = A_LTS; e.inv = 1'b1; end
               3'd5: begin e.alu = A_LTS; e.inv = 1'b0; end
               3'd6: begin e.alu = A_LTU; e.inv = 1'b1; end
               3'd7: begin e.alu = A_LTU; e.inv = 1'b0; end
               default: legal = 1'b0;
            endcase
         end
         7'h37: begin ur = 1'b1; e.alu = A_ADD; e.opa = 2'b10; e.opb = 1'b1; e.imm = iu; end
         7'h17: begin ur = 1'b1; e.alu = A_ADD; e.opa = 2'b01; e.opb = 1'b1; e.imm = iu; end
         7'h6F: begin ur = 1'b1; e.alu = A_ADD; e.pcm = 2'b11; e.opa = 2'b01; e.opb = 1'b1; e.imm = ij; end
         7'h67: begin
            ur = 1'b1; u1 = 1'b1; e.alu = A_ADD; e.pcm = 2'b10; e.opb = 1'b1; e.imm = ii;
            legal = (f3 == 3'd0);
         end
         7'h03: begin
            ur = 1'b1; u1 = 1'b1; e.alu = A_ADD; e.opb = 1'b1; e.imm = ii;
            case (f3)
               3'd0: e.lw = 2'b11;
               3'd1: e.lw = 2'b10;
               3'd2: e.lw = 2'b01;
               3'd4: begin e.lw = 2'b11; e.un = 1'b1; end
               3'd5: begin e.lw = 2'b10; e.un = 1'b1; end
               default: legal = 1'b0;
            endcase
         end
         7'h23: begin
            u1 = 1'b1; u2 = 1'b1; e.alu = A_ADD; e.opb = 1'b1; e.imm = is; e.st = 1'b1;
            case (f3)
               3'd0: e.lw = 2'b11;
               3'd1: e.lw = 2'b10;
               3'd2: e.lw = 2'b01;
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase
      if ((ur && i[11]) || (u1 && i[19]) || (u2 && i[24])) legal = 1'b0;
      if (!legal) begin
         e = '0;
         e.ill = 1'b1;
      end else begin
         e.rd  = ur ? i[10:7]  : 4'h0;
         e.rs1 = u1 ? i[18:15] : 4'h0;
         e.rs2 = u2 ? i[23:20] : 4'h0;
         e.rdw = ur && (i[11:7] != 5'd0);
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] i;
      logic [6:0] opcs [9];
      int k;
      opcs = '{7'h33, 7'h13, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23};
      i = $urandom;
      k = $urandom_range(0, 11);
      if (k < 9) i[6:0] = opcs[k];
      else if (k == 10) i[1:0] = 2'b01;
      else if (k == 11) i[6:0] = 7'h33;
      if ((i[6:0] == 7'h33 || i[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
         i[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
      if ($urandom_range(0, 3) != 0) i[11] = 1'b0;
      if ($urandom_range(0, 3) != 0) i[19] = 1'b0;
      if ($urandom_range(0, 3) != 0) i[24] = 1'b0;
      return i;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      InValid = 1'b0; Flush = 1'b1; OutReady = 1'b1;
      step();
      Flush = 1'b0;
   endtask

   task automatic send(input logic [31:0] instr, input logic [31:0] pc);
      InValid = 1'b1; InInstr = instr; InPc = pc; OutReady = 1'b1;
      step();
      InValid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (OutValid !== 1'b0 || InReady !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_hs: got valid=%b ready=%b want 0/1", OutValid, InReady);
      end
      n_checks++;
      if (OutPc !== RESET_PC) begin
         n_errors++;
         $display("FAIL reset_pc: got %h want %h", OutPc, RESET_PC);
      end
      n_checks++;
      if (observe() !== '0) begin
         n_errors++;
         $display("FAIL reset_bundle: got %h want 0", observe());
      end
      @(posedge clk); #1;
      Reset = 1'b0;
   endtask

   task automatic test_add();
      clear();
      send(32'h002081B3, 32'h0000_0100);
      n_checks++;
      if (OutValid !== 1'b1 || CtrlALUOp !== 4'b0101 || CtrlOpBSel !== 1'b0 || OutPc !== 32'h0000_0100) begin
         n_errors++;
         $display("FAIL add_op: got v=%b alu=%b opb=%b pc=%h want 1/0101/0/00000100",
                  OutValid, CtrlALUOp, CtrlOpBSel, OutPc);
      end
      n_checks++;
      if (RdAddr !== 4'd3 || Rs1Addr !== 4'd1 || Rs2Addr !== 4'd2 || RdWrite !== 1'b1 || Illegal !== 1'b0) begin
         n_errors++;
         $display("FAIL add_regs: got rd=%0d rs1=%0d rs2=%0d we=%b ill=%b want 3/1/2/1/0",
                  RdAddr, Rs1Addr, Rs2Addr, RdWrite, Illegal);
      end
   endtask

   task automatic test_bltu();
      send(32'hFE20EEE3, 32'h0000_0104);
      n_checks++;
      if (CtrlALUOp !== 4'b1110 || CtrlFlagInv !== 1'b1 || CtrlPCMode !== 2'b01 ||
          Imm !== 32'hFFFF_FFFC || RdWrite !== 1'b0) begin
         n_errors++;
         $display("FAIL bltu: got alu=%b inv=%b pcm=%b imm=%h we=%b want 1110/1/01/fffffffc/0",
                  CtrlALUOp, CtrlFlagInv, CtrlPCMode, Imm, RdWrite);
      end
   endtask

   task automatic test_lhu();
      send(32'h0080D283, 32'h0000_0108);
      n_checks++;
      if (CtrlLSUWidth !== 2'b10 || CtrlLSUUnsigned !== 1'b1 || Imm !== 32'd8 ||
          CtrlOpBSel !== 1'b1 || CtrlLSUStore !== 1'b0) begin
         n_errors++;
         $display("FAIL lhu: got w=%b u=%b imm=%h opb=%b st=%b want 10/1/8/1/0",
                  CtrlLSUWidth, CtrlLSUUnsigned, Imm, CtrlOpBSel, CtrlLSUStore);
      end
   endtask

   task automatic test_illegal_x16();
      exp_t want;
      want = '0;
      want.ill = 1'b1;
      send(32'h00208833, 32'h0000_010C);
      n_checks++;
      if (observe() !== want || OutPc !== 32'h0000_010C) begin
         n_errors++;
         $display("FAIL illegal_x16: got %h pc=%h want %h pc=0000010c", observe(), OutPc, want);
      end
   endtask

   task automatic test_backpressure();
      clear();
      OutReady = 1'b0; InValid = 1'b1;
      InInstr = 32'h002081B3; InPc = 32'h200; step();
      InInstr = 32'h00208233; InPc = 32'h204; step();
      n_checks++;
      if (InReady !== 1'b0 || OutValid !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_full: got ready=%b valid=%b want 0/1", InReady, OutValid);
      end
      InInstr = 32'h002082B3; InPc = 32'h208; step();
      n_checks++;
      if (RdAddr !== 4'd3 || OutPc !== 32'h200 || InReady !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_hold: got rd=%0d pc=%h ready=%b want 3/200/0", RdAddr, OutPc, InReady);
      end
      InValid = 1'b0; OutReady = 1'b1; step();
      n_checks++;
      if (OutValid !== 1'b1 || RdAddr !== 4'd4 || OutPc !== 32'h204 || InReady !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_second: got v=%b rd=%0d pc=%h ready=%b want 1/4/204/1",
                  OutValid, RdAddr, OutPc, InReady);
      end
      step();
      n_checks++;
      if (OutValid !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_drain: got valid=%b want 0", OutValid);
      end
   endtask

   task automatic test_flush();
      clear();
      OutReady = 1'b0; InValid = 1'b1;
      InInstr = 32'h002081B3; InPc = 32'h300; step();
      InInstr = 32'h00208233; InPc = 32'h304; step();
      Flush = 1'b1; InInstr = 32'h002082B3; InPc = 32'h308; step();
      Flush = 1'b0; InValid = 1'b0;
      n_checks++;
      if (OutValid !== 1'b0 || InReady !== 1'b1) begin
         n_errors++;
         $display("FAIL flush: got valid=%b ready=%b want 0/1", OutValid, InReady);
      end
      OutReady = 1'b1; step();
      n_checks++;
      if (OutValid !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_drop: got valid=%b want 0", OutValid);
      end
   endtask

   task automatic test_async_reset();
      clear();
      OutReady = 1'b0; InValid = 1'b1;
      InInstr = 32'h0080D283; InPc = 32'h400; step();
      InInstr = 32'hFE20EEE3; InPc = 32'h404; step();
      InValid = 1'b0;
      #2 Reset = 1'b1;
      #1;
      n_checks++;
      if (OutValid !== 1'b0 || InReady !== 1'b1 || OutPc !== RESET_PC || observe() !== '0) begin
         n_errors++;
         $display("FAIL async_reset: got v=%b r=%b pc=%h bundle=%h want 0/1/%h/0",
                  OutValid, InReady, OutPc, observe(), RESET_PC);
      end
      @(posedge clk); #1;
      Reset = 1'b0;
      OutReady = 1'b1; step();
      n_checks++;
      if (OutValid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_drop: got valid=%b want 0", OutValid);
      end
   endtask

   // Random stream: the stage must behave as a 2-deep FIFO of model(instr)
   task automatic test_random_stream(input int cycles);
      entry_t q[$];
      entry_t ent;
      logic pop, push;
      clear();
      for (int c = 0; c < cycles; c++) begin
         InValid  = ($urandom_range(0, 9) < 7);
         OutReady = ($urandom_range(0, 9) < 5);
         Flush    = ($urandom_range(0, 31) == 0);
         InInstr  = rand_instr();
         InPc     = $urandom & 32'hFFFF_FFFE;
         #1;
         n_checks++;
         if (OutValid !== (q.size() > 0) || InReady !== (q.size() < 2)) begin
            n_errors++;
            $display("FAIL rnd_hs cyc %0d: got valid=%b ready=%b want %b/%b",
                     c, OutValid, InReady, q.size() > 0, q.size() < 2);
         end
         if (q.size() > 0) begin
            n_checks++;
            if (observe() !== q[0].c || OutPc !== q[0].pc) begin
               n_errors++;
               $display("FAIL rnd_entry cyc %0d: got %h pc=%h want %h pc=%h",
                        c, observe(), OutPc, q[0].c, q[0].pc);
            end
         end
         pop  = (q.size() > 0) && OutReady;
         push = InValid && (q.size() < 2);
         ent.c  = model(InInstr);
         ent.pc = InPc;
         if (Flush) begin
            q.delete();
         end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(ent);
         end
         @(posedge clk);
         #1;
      end
      Flush = 1'b0;
      InValid = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; InValid = 1'b0; InInstr = 32'h0; InPc = 32'h0;
      Flush = 1'b0; OutReady = 1'b0;
      test_reset();
      test_add();
      test_bltu();
      test_lhu();
      test_illegal_x16();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_random_stream(3000);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32E instruction decode stage for the MC-RV32EC core. It sits between fetch (after compressed-instruction expansion) and execute, and produces the control bundle that drives the integer unit, PC-write logic and LSU. The stage translates each 32-bit instruction into ALU category/select, flag inversion, PC mode, LSU width, operand selects, immediate and register indices. Output goes through a 2-entry skid buffer with valid/ready on both sides, so `InReady` is registered.

## Interface
- `ResetPc`, default 32'h0000_0000: value of `OutPc` under reset.
- `Clk` input 1: single clock, rising edge.
- `Reset` input 1: asynchronous, active-high.
- `InValid`, `InReady` input/output 1: upstream handshake.
- `InInstr` input 32: expanded 32-bit instruction.
- `InPc` input 32: instruction address.
- `Flush` input 1: discard all held and incoming entries.
- `OutValid`, `OutReady` output/input 1: downstream handshake.
- `OutPc` output 32: PC of the held instruction.
- `CtrlALUOp` output 4: {category, select}, shared enum encodings.
- `CtrlFlagInv` output 1: invert the comparison flag.
- `CtrlPCMode` output 2: PCINC/PCBRCH/PCJREG/PCJIMM.
- `CtrlLSUWidth` output 2: LSN/LSW/LSH/LSB.
- `CtrlLSUStore`, `CtrlLSUUnsigned` output 1 each.
- `CtrlOpASel` output 2: 00 Rs1, 01 PC, 10 zero.
- `CtrlOpBSel` output 1: 0 Rs2, 1 Imm.
- `Imm` output 32: sign-extended I/S/B/U/J immediate.
- `RdAddr`, `Rs1Addr`, `Rs2Addr` output 4 each.
- `RdWrite` output 1: register write enable; forced 0 when rd=x0.
- `Illegal` output 1: instruction is illegal. The other control fields in the entry are the zero (NOP) bundle, apart from `OutPc`.

## Operation
- OP/OP-IMM, selected by funct3:
  - 000 gives ALUAS AFADD. OP with funct7[5]=1 gives AFSUBU instead.
  - 001 gives ALUSH SHSLL.
  - 010 gives ALUFL AFSUBS with FlagInv=1.
  - 011 gives ALUFL AFSUBU with FlagInv=1.
  - 100 gives ALUBT BTXOR.
  - 101 gives SHSRL, or SHSRA when funct7[5]=1.
  - 110 gives BTOR; 111 gives BTAND.
  - Shift funct7 other than 0x00/0x20 is illegal. OP funct7 other than 0x00, or 0x20 on 000/101, is illegal.
- BRANCH: category ALUFL, PCBRCH, OpB=Rs2.
  - 000 AFEQU, Inv 0.
  - 001 AFEQU, Inv 1.
  - 100 AFSUBS, Inv 1.
  - 101 AFSUBS, Inv 0.
  - 110 AFSUBU, Inv 1.
  - 111 AFSUBU, Inv 0.
  - 010 and 011 are illegal.
- LUI: OpA=zero, AFADD. AUIPC: OpA=PC, AFADD.
- JAL: PCJIMM, RdWrite=1. JALR: PCJREG, funct3 must be 000.
- LOAD, funct3: 000 LSB, 001 LSH, 010 LSW, 100 LSB+Unsigned, 101 LSH+Unsigned; others illegal.
- STORE, funct3: 000, 001, 010 only, with Store=1 and RdWrite=0.
- LOAD/STORE use ADD with OpB=Imm.
- Any other opcode, or low bits ≠ 11, is illegal.
- RV32E check: bit 4 set in any *used* rd/rs1/rs2 field is illegal.
- Skid buffer holds a main entry (drives outputs) and a skid entry.
  - `InReady = ~SkidValid`.
  - On accept: if main is empty or `OutReady`=1, the entry loads into main. Otherwise it goes to skid.
  - On `OutReady` with skid full: skid moves to main and skid empties.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented with `OutValid`=1 after N.
- Full throughput when `OutReady` is held at 1.
- Outputs hold stable while `OutValid`=1 and `OutReady`=0.
- `Flush` at an edge clears both valids and drops any same-cycle accept. `InReady` returns to 1 the next cycle.
- Reset (asynchronous) values:
  - Valids are 0 and `InReady`=1.
  - All control outputs, `Imm` and register indices are 0; `Illegal` is 0.
  - `OutPc` = `ResetPc`.
- Reset mid-transfer drops both entries.
- `OutValid` never drops without a handshake or flush.

## Structure
- Shared package `ctrl_sig_pkg` holds:
  - ALU category/select enums (ALUBT/ALUAS/ALUSH/ALUFL, BT*, AF*, SH*).
  - PC-mode and LSU-width enums.
  - RV32 opcode constants.
  - A packed `ctrl_bundle_t` struct carrying every registered output except PC.
- Sub-module `rv32e_decoder` is purely combinational: instruction in, `ctrl_bundle_t` out. `decode_stage` registers its output through the skid buffer.

## Test plan
- `add x3,x1,x2` (0x002081B3), `OutReady`=1 → next cycle:
  - ALUOp=0101, OpB=0.
  - RdAddr=3, Rs1=1, Rs2=2, RdWrite=1, Illegal=0.
- `bltu x1,x2,-4` (0xFE20EEE3):
  - ALUOp=1110, FlagInv=1, PCMode=01.
  - Imm=0xFFFFFFFC, RdWrite=0.
- `lhu x5,8(x1)` (0x0080D283): LSUWidth=10, Unsigned=1, Imm=8, OpB=1.
- `add x16,x1,x2` (0x00208833) → Illegal=1 and the rest of the bundle is zero.
- Backpressure: hold `OutReady`=0 and send 3 instructions.
  - Two are accepted; `InReady`=0 after the second accept.
  - Release `OutReady` → outputs come out in order, with no duplication or loss.
- `Flush` with both entries full and `InValid`=1 → next cycle `OutValid`=0 and `InReady`=1. Asynchronous `Reset` mid-stream → all outputs are at reset values immediately.
